ad7606_conv_ctrl: RTL and testbench
===================================

Name: ad7606_conv_ctrl

Overview:
Sequencer for the AD7606 front end. It owns the CONVST, RESET and OS[2:0] pins, schedules conversions at a programmable sample period, and hands each completed conversion to the SPI reader via a start/done handshake. It takes decoded 16-bit command words from the PC-side UART command path and reports status back through sticky flags.

Parameters:
CONVST_LOW_CYC, 4, CONVST low pulse width in clk cycles (1..15).
RESET_CYC, 8, ad_reset high width in clk cycles (1..255).
BUSY_TIMEOUT, 1000, max clk cycles spent waiting in each BUSY phase and for rd_done.
DEFAULT_PERIOD, 5000, sample period in clk cycles after reset.
MIN_PERIOD, 64, lower clamp on a programmed period.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cmd_data  in  16  command word: [15:12] opcode, [11:0] argument
cmd_valid  in  1  one-cycle strobe qualifying cmd_data
busy  in  1  AD7606 BUSY, already synchronised to clk
rd_start  out  1  one-cycle pulse telling the SPI reader to fetch all 8 channels
rd_done  in  1  one-cycle pulse from the SPI reader when the frame is in the SPI FIFO
fifo_afull  in  1  SPI FIFO almost-full
convst  out  1  AD7606 CONVST (idle high)
ad_reset  out  1  AD7606 RESET (active high)
os  out  3  oversampling ratio pins
running  out  1  continuous mode active
overrun_err  out  1  sticky: one or more sample ticks were missed
timeout_err  out  1  sticky: a BUSY or rd_done timeout occurred

Behaviour:
- Reset values while rst=1:
  - Outputs: convst=1, ad_reset=0, os=0, rd_start=0, running=0, overrun_err=0, timeout_err=0.
  - Internals: period=DEFAULT_PERIOD, state=RST_AD.
- Commands are decoded only when cmd_valid=1. Opcodes:
  - 0x1: start continuous (running<=1).
  - 0x2: stop. running<=0; the in-flight conversion completes, then IDLE.
  - 0x3: os<=arg[2:0]. Honoured only in IDLE; otherwise ignored.
  - 0x4: period<=max(arg*16, MIN_PERIOD). Takes effect at the next period load.
  - 0x5: single shot. Honoured only in IDLE with running=0.
  - 0x6: AD reset. Aborts any state, running<=0, go to RST_AD.
  - 0x7: clear overrun_err and timeout_err.
  - Any other opcode is ignored.
- States:
  - RST_AD: ad_reset=1 for RESET_CYC cycles, then IDLE. Entered on the first cycle after rst deasserts.
  - IDLE: convst=1.
    - Start: go to CONV the next cycle.
    - Single shot: go to CONV the next cycle with a one-shot flag set.
  - CONV: convst=0 for exactly CONVST_LOW_CYC cycles, then convst=1 and go to WAIT_HI. The period counter loads period-1 on CONV entry.
  - WAIT_HI: wait for busy=1, then WAIT_LO.
  - WAIT_LO: wait for busy=0, then READ.
  - READ: rd_start=1 on the entry cycle only, then wait for rd_done.
    - On rd_done: if running=1 and not one-shot, go to WAIT_PER; else go to IDLE.
  - WAIT_PER: when the period counter reaches 0, go to CONV. If fifo_afull=1 at that moment, skip the tick, set overrun_err, reload the counter and stay.
- Period counter:
  - Free-decrements from each CONV entry.
  - If it reaches 0 while in CONV, WAIT_HI, WAIT_LO or READ, set overrun_err. The next CONV starts immediately on the return to WAIT_PER (no extra queueing).
- Timeouts:
  - A per-state cycle counter resets on every state entry.
  - Reaching BUSY_TIMEOUT in WAIT_HI, WAIT_LO or READ sets timeout_err, clears running, and goes to IDLE. No rd_start is issued after a BUSY timeout.
- Simultaneous events:
  - AD reset (0x6) overrides everything, including a timeout in the same cycle.
  - A timeout in the same cycle as stop: timeout_err is set and the state goes to IDLE.
  - Clear-errors (0x7) in the same cycle as a new error: the error wins and the flag stays set.
- A start in a non-IDLE state only sets running=1; it does not restart the current conversion.
- rd_done outside READ is ignored.
- Sample-to-sample spacing is exactly `period` clk cycles when no overrun occurs.

Test Plan:
- Reset release:
  - rst 1→0 -> ad_reset=1 for 8 cycles, then IDLE.
  - convst=1 and os=0 throughout.
- Single shot:
  - cmd 0x5000 with a BUSY model (high 2 cycles after convst rises, low 40 cycles later) and rd_done 20 cycles after rd_start.
  - Required: convst low exactly 4 cycles, one rd_start pulse, back to IDLE, running stays 0.
- Continuous:
  - cmd 0x4010 (period 256) then 0x1000.
  - Required: CONV entries exactly 256 cycles apart over 10 samples; no error flags.
  - Then 0x2000 mid-READ -> the frame completes and no further convst.
- Overrun:
  - period=64 with rd_done delayed 100 cycles -> overrun_err=1 and the next convst follows immediately after rd_done.
  - fifo_afull=1 at a tick -> no convst at that tick and overrun_err=1.
  - 0x7000 clears the flag.
- Timeout:
  - Hold busy=0 after convst -> at 1000 cycles in WAIT_HI: timeout_err=1, running=0, IDLE, no rd_start.
- OS and abort:
  - 0x3005 in IDLE -> os=5.
  - 0x3002 during WAIT_LO -> os stays 5.
  - 0x6000 during WAIT_LO -> ad_reset for 8 cycles, running=0, then IDLE.

Source files
------------

// File: rtl/ad7606_conv_ctrl.sv
// AD7606 conversion sequencer: drives CONVST/RESET/OS, paces samples at a
// programmable period and hands finished conversions to the SPI reader.
module ad7606_conv_ctrl #(
    parameter int unsigned CONVST_LOW_CYC = 4,
    parameter int unsigned RESET_CYC      = 8,
    parameter int unsigned BUSY_TIMEOUT   = 1000,
    parameter int unsigned DEFAULT_PERIOD = 5000,
    parameter int unsigned MIN_PERIOD     = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cmd_data,
    input  logic        cmd_valid,
    input  logic        busy,
    output logic        rd_start,
    input  logic        rd_done,
    input  logic        fifo_afull,
    output logic        convst,
    output logic        ad_reset,
    output logic [2:0]  os,
    output logic        running,
    output logic        overrun_err,
    output logic        timeout_err
);

    localparam int unsigned CNT_W = $clog2(BUSY_TIMEOUT + RESET_CYC + CONVST_LOW_CYC + 1);
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RESET_CYC);
    localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(CONVST_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [15:0]      MIN_PER   = 16'(MIN_PERIOD);
    localparam logic [15:0]      DEF_PER   = 16'(DEFAULT_PERIOD);

    typedef enum logic [2:0] {
        RST_AD,
        IDLE,
        CONV,
        WAIT_HI,
        WAIT_LO,
        READ,
        WAIT_PER
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] st_cnt;
    logic [15:0]      period;
    logic [15:0]      per_cnt;
    logic             one_shot;
    logic             tick_late;

    logic [3:0]  opcode;
    logic [11:0] arg;
    logic [15:0] arg_period;
    logic        cmd_start, cmd_stop, cmd_os, cmd_period, cmd_shot, cmd_abort, cmd_clear;
    logic        in_conversion;
    logic        timed_out;

    always_comb begin
        opcode     = cmd_data[15:12];
        arg        = cmd_data[11:0];
        cmd_start  = cmd_valid && (opcode == 4'h1);
        cmd_stop   = cmd_valid && (opcode == 4'h2);
        cmd_os     = cmd_valid && (opcode == 4'h3);
        cmd_period = cmd_valid && (opcode == 4'h4);
        cmd_shot   = cmd_valid && (opcode == 4'h5);
        cmd_abort  = cmd_valid && (opcode == 4'h6);
        cmd_clear  = cmd_valid && (opcode == 4'h7);
        arg_period = {arg, 4'b0000};
        if (arg_period < MIN_PER) begin
            arg_period = MIN_PER;
        end
        in_conversion = state inside {CONV, WAIT_HI, WAIT_LO, READ};
        timed_out     = (st_cnt == TO_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RST_AD;
            st_cnt      <= '0;
            period      <= DEF_PER;
            per_cnt     <= '0;
            one_shot    <= 1'b0;
            tick_late   <= 1'b0;
            convst      <= 1'b1;
            ad_reset    <= 1'b0;
            os          <= '0;
            rd_start    <= 1'b0;
            running     <= 1'b0;
            overrun_err <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            rd_start <= 1'b0;
            st_cnt   <= st_cnt + CNT_ONE;
            if (per_cnt != '0) begin
                per_cnt <= per_cnt - 16'd1;
            end
            if (cmd_period) begin
                period <= arg_period;
            end
            if (cmd_start) begin
                running <= 1'b1;
            end
            if (cmd_stop) begin
                running <= 1'b0;
            end
            // Clear comes first so a same-cycle error below keeps its flag set.
            if (cmd_clear) begin
                overrun_err <= 1'b0;
                timeout_err <= 1'b0;
            end

            if (cmd_abort) begin
                state    <= RST_AD;
                st_cnt   <= CNT_ONE;
                ad_reset <= 1'b1;
                convst   <= 1'b1;
                running  <= 1'b0;
                one_shot <= 1'b0;
            end else begin
                // Tick expired mid-conversion: flag once, next CONV fires on return to WAIT_PER.
                if (running && !one_shot && in_conversion && per_cnt == '0 && !tick_late) begin
                    overrun_err <= 1'b1;
                    tick_late   <= 1'b1;
                end
                case (state)
                    RST_AD: begin
                        if (st_cnt == RST_LAST) begin
                            ad_reset <= 1'b0;
                            state    <= IDLE;
                            st_cnt   <= '0;
                        end else begin
                            ad_reset <= 1'b1;
                        end
                    end
                    IDLE: begin
                        if (cmd_os) begin
                            os <= arg[2:0];
                        end
                        if (cmd_start || running) begin
                            state     <= CONV;
                            st_cnt    <= '0;
                            convst    <= 1'b0;
                            per_cnt   <= period - 16'd1;
                            tick_late <= 1'b0;
                        end else if (cmd_shot) begin
                            state     <= CONV;
                            st_cnt    <= '0;
                            convst    <= 1'b0;
                            per_cnt   <= period - 16'd1;
                            tick_late <= 1'b0;
                            one_shot  <= 1'b1;
                        end
                    end
                    CONV: begin
                        if (st_cnt == CONV_LAST) begin
                            convst <= 1'b1;
                            state  <= WAIT_HI;
                            st_cnt <= '0;
                        end
                    end
                    WAIT_HI: begin
                        if (busy) begin
                            state  <= WAIT_LO;
                            st_cnt <= '0;
                        end else if (timed_out) begin
                            timeout_err <= 1'b1;
                            running     <= 1'b0;
                            one_shot    <= 1'b0;
                            state       <= IDLE;
                            st_cnt      <= '0;
                        end
                    end
                    WAIT_LO: begin
                        if (!busy) begin
                            state    <= READ;
                            st_cnt   <= '0;
                            rd_start <= 1'b1;
                        end else if (timed_out) begin
                            timeout_err <= 1'b1;
                            running     <= 1'b0;
                            one_shot    <= 1'b0;
                            state       <= IDLE;
                            st_cnt      <= '0;
                        end
                    end
                    READ: begin
                        if (rd_done) begin
                            state    <= (running && !one_shot) ? WAIT_PER : IDLE;
                            st_cnt   <= '0;
                            one_shot <= 1'b0;
                        end else if (timed_out) begin
                            timeout_err <= 1'b1;
                            running     <= 1'b0;
                            one_shot    <= 1'b0;
                            state       <= IDLE;
                            st_cnt      <= '0;
                        end
                    end
                    WAIT_PER: begin
                        if (!running || cmd_stop) begin
                            state  <= IDLE;
                            st_cnt <= '0;
                        end else if (per_cnt == '0) begin
                            if (fifo_afull) begin
                                overrun_err <= 1'b1;
                                per_cnt     <= period - 16'd1;
                            end else begin
                                state     <= CONV;
                                st_cnt    <= '0;
                                convst    <= 1'b0;
                                per_cnt   <= period - 16'd1;
                                tick_late <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        st_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ad7606_conv_ctrl.sv
// Directed/randomized bench for ad7606_conv_ctrl with a BUSY/SPI-reader model
// and expectations derived from sample-period arithmetic.
module tb_ad7606_conv_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cmd_data;
    logic        cmd_valid;
    logic        busy;
    logic        rd_start;
    logic        rd_done;
    logic        fifo_afull;
    logic        convst;
    logic        ad_reset;
    logic [2:0]  os;
    logic        running;
    logic        overrun_err;
    logic        timeout_err;

    ad7606_conv_ctrl #(
        .CONVST_LOW_CYC(4),
        .RESET_CYC(8),
        .BUSY_TIMEOUT(1000),
        .DEFAULT_PERIOD(5000),
        .MIN_PERIOD(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cmd_data(cmd_data),
        .cmd_valid(cmd_valid),
        .busy(busy),
        .rd_start(rd_start),
        .rd_done(rd_done),
        .fifo_afull(fifo_afull),
        .convst(convst),
        .ad_reset(ad_reset),
        .os(os),
        .running(running),
        .overrun_err(overrun_err),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // BUSY and SPI-reader behaviour knobs
    bit busy_en = 1'b0;
    bit rd_en = 1'b0;
    int busy_dly = 2;
    int busy_hi = 40;
    int rd_dly = 20;

    // Observation state, sampled on the falling edge
    int   cyc = 0;
    int   n_fall = 0;
    int   n_rd = 0;
    int   low_cnt = 0;
    int   last_low = 0;
    int   rd_done_cyc = 0;
    logic prev_convst = 1'b1;
    int   fall_q[$];

    always @(negedge clk) begin
        cyc         <= cyc + 1;
        prev_convst <= convst;
        if (prev_convst && !convst) begin
            fall_q.push_back(cyc);
            n_fall <= n_fall + 1;
        end
        if (!convst) begin
            low_cnt <= low_cnt + 1;
        end else if (!prev_convst) begin
            last_low <= low_cnt;
            low_cnt  <= 0;
        end
        if (rd_start) n_rd <= n_rd + 1;
        if (rd_done) rd_done_cyc <= cyc;
    end

    initial begin
        busy = 1'b0;
        forever begin
            @(posedge convst);
            if (busy_en) begin
                repeat (busy_dly) @(negedge clk);
                busy = 1'b1;
                repeat (busy_hi) @(negedge clk);
                busy = 1'b0;
            end
        end
    end

    initial begin
        rd_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rd_start && rd_en) begin
                repeat (rd_dly - 1) @(negedge clk);
                rd_done = 1'b1;
                @(negedge clk);
                rd_done = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=still running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [15:0] w);
        @(negedge clk);
        cmd_data  = w;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_data  = '0;
    endtask

    task automatic wait_falls(input int target, input int budget, input string tag);
        int k = 0;
        while (fall_q.size() < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(fall_q.size() >= target), 1);
    endtask

    task automatic wait_rd(input int after, input int budget, input string tag);
        int k = 0;
        while (n_rd <= after && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(n_rd > after), 1);
    endtask

    // Continuous run at period max(arg*16, 64), then stop while a frame is being read.
    task automatic run_round(input logic [11:0] arg, input int nsamp);
        int per, base, r0, f1;
        per = int'(arg) * 16;
        if (per < 64) per = 64;
        busy_hi = $urandom_range(5, 20);
        rd_dly  = $urandom_range(3, 10);
        send_cmd({4'h4, arg});
        base = fall_q.size();
        send_cmd(16'h1000);
        wait_falls(base + nsamp, per * (nsamp + 1) + 200, "cont_wait");
        if (fall_q.size() >= base + nsamp) begin
            for (int i = 1; i < nsamp; i++) begin
                chk("cont_spacing", fall_q[base+i] - fall_q[base+i-1], per);
            end
        end
        chk("cont_low_width", last_low, 4);
        chk("cont_overrun", overrun_err, 0);
        chk("cont_timeout", timeout_err, 0);
        chk("cont_running", running, 1);
        r0 = n_rd;
        wait_rd(r0, per + 100, "stop_wait_read");
        send_cmd(16'h2000);
        f1 = fall_q.size();
        repeat (per + 60) @(negedge clk);
        chk("stop_no_convst", fall_q.size() - f1, 0);
        chk("stop_frame_done", n_rd - r0, 1);
        chk("stop_running", running, 0);
    endtask

    initial begin
        int hi, bad, f0, r0, base, t0, d, k;
        rst        = 1'b1;
        cmd_data   = '0;
        cmd_valid  = 1'b0;
        fifo_afull = 1'b0;
        repeat (4) @(negedge clk);

        chk("rst_convst", convst, 1);
        chk("rst_ad_reset", ad_reset, 0);
        chk("rst_os", os, 0);
        chk("rst_rd_start", rd_start, 0);
        chk("rst_running", running, 0);
        chk("rst_overrun", overrun_err, 0);
        chk("rst_timeout", timeout_err, 0);

        rst = 1'b0;
        hi = 0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ad_reset) hi++;
            if (convst !== 1'b1 || os !== 3'd0) bad++;
        end
        chk("reset_ad_width", hi, 8);
        chk("reset_idle_pins", bad, 0);

        // Single shot
        busy_en  = 1'b1;
        rd_en    = 1'b1;
        busy_dly = 2;
        busy_hi  = 40;
        rd_dly   = 20;
        f0 = n_fall;
        r0 = n_rd;
        send_cmd(16'h5000);
        repeat (150) @(negedge clk);
        chk("shot_falls", n_fall - f0, 1);
        chk("shot_low_width", last_low, 4);
        chk("shot_rd_start", n_rd - r0, 1);
        chk("shot_running", running, 0);
        chk("shot_convst", convst, 1);

        // Continuous at several periods, including the lower clamp
        run_round(12'h010, 10);
        run_round(12'($urandom_range(5, 25)), 5);
        run_round(12'd3, 5);

        // Overrun: read takes longer than the period
        send_cmd(16'h7000);
        busy_hi = 10;
        rd_dly  = 100;
        send_cmd(16'h4004);
        base = fall_q.size();
        send_cmd(16'h1000);
        wait_falls(base + 2, 400, "ovr_wait");
        if (fall_q.size() >= base + 2) begin
            d = fall_q[base+1] - rd_done_cyc;
            chk("ovr_next_conv", 32'(d >= 1 && d <= 2), 1);
        end
        chk("ovr_flag", overrun_err, 1);
        send_cmd(16'h2000);
        repeat (250) @(negedge clk);
        chk("ovr_stop_running", running, 0);
        chk("ovr_sticky", overrun_err, 1);
        send_cmd(16'h7000);
        chk("ovr_clear", overrun_err, 0);

        // Overrun: FIFO almost full at a tick
        rd_dly = 5;
        base = fall_q.size();
        send_cmd(16'h1000);
        wait_falls(base + 2, 300, "afull_wait");
        fifo_afull = 1'b1;
        t0 = (fall_q.size() >= base + 2) ? fall_q[base+1] : 0;
        repeat (90) @(negedge clk);
        fifo_afull = 1'b0;
        chk("afull_flag", overrun_err, 1);
        chk("afull_skip", fall_q.size() - base, 2);
        wait_falls(base + 3, 100, "afull_resume_wait");
        if (fall_q.size() >= base + 3) begin
            chk("afull_next", fall_q[base+2] - t0, 128);
        end
        send_cmd(16'h2000);
        repeat (100) @(negedge clk);
        send_cmd(16'h7000);
        chk("afull_clear", overrun_err, 0);

        // Timeout in WAIT_HI: BUSY never rises
        send_cmd(16'h4FFF);
        busy_en = 1'b0;
        r0 = n_rd;
        base = fall_q.size();
        send_cmd(16'h1000);
        wait_falls(base + 1, 20, "to_wait");
        t0 = (fall_q.size() >= base + 1) ? fall_q[base] : cyc;
        while (cyc < t0 + 990) @(negedge clk);
        chk("to_early", timeout_err, 0);
        while (cyc < t0 + 1020) @(negedge clk);
        chk("to_flag", timeout_err, 1);
        chk("to_running", running, 0);
        chk("to_no_rd_start", n_rd - r0, 0);
        repeat (50) @(negedge clk);
        chk("to_no_convst", fall_q.size() - base, 1);
        send_cmd(16'h3005);
        chk("os_set_idle", os, 5);

        // OS ignored and AD reset abort during WAIT_LO
        busy_en = 1'b1;
        busy_hi = 40;
        rd_dly  = 20;
        r0 = n_rd;
        send_cmd(16'h1000);
        k = 0;
        while (busy !== 1'b1 && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk("abort_busy_seen", busy, 1);
        repeat (3) @(negedge clk);
        send_cmd(16'h3002);
        chk("os_ignored", os, 5);
        send_cmd(16'h6000);
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            if (ad_reset) hi++;
            @(negedge clk);
        end
        chk("abort_ad_width", hi, 8);
        chk("abort_running", running, 0);
        repeat (80) @(negedge clk);
        chk("abort_no_rd_start", n_rd - r0, 0);
        chk("abort_convst", convst, 1);
        send_cmd(16'h3001);
        chk("abort_idle_os", os, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
